ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, clock cycles ps2_clock is held low before the start bit (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, maximum cycles between device clock falling edges, or from clock release to the first edge (15 ms).
REQ-003 Parameter WAIT_IDLE_CYCLES, default 50000, maximum cycles for the bus to return idle after ack.
REQ-004 clock  input  1  system clock (50 MHz); the only clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 tx_data  input  8  command byte to send to the device.
REQ-007 tx_valid  input  1  request; accepted when tx_valid and tx_ready are both high on a rising clock edge.
REQ-008 tx_ready  output  1  high only in IDLE.
REQ-009 tx_done  output  1  one-cycle pulse when the byte is acknowledged and the bus is idle.
REQ-010 tx_error  output  1  one-cycle pulse on failure.
REQ-011 err_code  output  2  valid with tx_error: 01 timeout, 10 no ack, 11 idle timeout; holds its last value otherwise.
REQ-012 ps2_clock_in, ps2_data_in  input  1 each  raw pad levels (asynchronous).
REQ-013 ps2_clock_oe, ps2_data_oe  output  1 each  1 = drive the pad low; 0 = release it. The top level builds the open-drain inout.

Function
REQ-014 Both pad inputs SHALL pass a 2-flop synchronizer; a falling edge is previous synchronized value 1 and current 0 (3-cycle detection latency).
REQ-015 States SHALL be: IDLE, INHIBIT, START, BITS, STOP, ACK, WAIT_IDLE.
REQ-016 IDLE: both oe = 0. On accept, latch tx_data, compute odd parity (parity = ~^tx_data), go to INHIBIT.
REQ-017 INHIBIT: ps2_clock_oe = 1 for exactly INHIBIT_CYCLES; data_oe = 1 in the last cycle (start bit); then go to START.
REQ-018 START: clock_oe = 0, data_oe = 1; the timeout counter starts; falling edge 1 goes to BITS.
REQ-019 BITS: on falling edges 1..8, data_oe = ~data[bit] (LSB first); on edge 9, data_oe = ~parity; after edge 9, go to STOP.
REQ-020 STOP: on edge 10, data_oe = 0 (stop = 1); go to ACK.
REQ-021 ACK: on edge 11, sample synchronized data. If 0, go to WAIT_IDLE. If 1, pulse tx_error with err_code 10 and go to IDLE.
REQ-022 WAIT_IDLE: when both synchronized lines are 1, pulse tx_done and go to IDLE. Exceeding WAIT_IDLE_CYCLES pulses tx_error with err_code 11.
REQ-023 The timeout counter resets on every falling edge. Reaching TIMEOUT_CYCLES in START/BITS/STOP/ACK pulses tx_error with err_code 01, sets both oe to 0 that cycle, and goes to IDLE.
REQ-024 tx_done and tx_error SHALL never assert in the same cycle; the next request is accepted no earlier than the cycle after either pulse.
REQ-025 tx_valid while busy SHALL be ignored (no queueing); tx_data changes after accept SHALL have no effect.
REQ-026 Falling edges seen in IDLE or INHIBIT SHALL be ignored.
REQ-027 Counters SHALL be sized for their parameter and saturate, never wrap; the bit counter is 4 bits.

Reset
REQ-028 Asserting reset (low) at any time, including mid-frame, SHALL immediately give: state IDLE, both oe 0, tx_ready 1, tx_done 0, tx_error 0, err_code 00, all counters 0, synchronizers 1.
REQ-029 The first accept is possible on the first clock edge after reset deasserts.

Structure
REQ-030 A shared package ps2_pkg SHALL hold the state enum, the err_code constants, and the frame constants (11 edges, odd parity). The existing PS/2 receiver uses the same package.
REQ-031 One sub-module ps2_sync_edge (2-flop synchronizer plus falling-edge detector, one instance per line) SHALL be used; everything else is a single FSM.

Verification
REQ-032 tx_data = 8'hED with a device model at 12.5 kHz acking on edge 11 -> clock_oe low 5000 cycles; bits sampled on rising edges 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; err_code stays 00.
REQ-033 tx_data = 8'h00 with the device not acking (data high on edge 11) -> parity 1 sent; tx_error with err_code 10; both oe 0; tx_ready 1 the next cycle.
REQ-034 Device stops clocking after edge 5 -> tx_error with err_code 01 exactly TIMEOUT_CYCLES after edge 5 (plus sync latency); lines released.
REQ-035 reset asserted during BITS at edge 4 -> both oe 0 in the same cycle, no tx_done or tx_error; a new 8'hF4 sends correctly after release.
REQ-036 tx_valid held high through a whole 8'hFF frame with tx_data changed mid-frame -> one frame only, 8'hFF with parity 1; a second frame starts only after tx_done.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: state, error-code and frame definitions shared by the PS/2 host transmitter and receiver.
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, START, BITS, STOP, ACK, WAIT_IDLE} ps2_state_t;
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NO_ACK  = 2'b10;
    localparam logic [1:0] ERR_IDLE    = 2'b11;
    localparam int FRAME_EDGES = 11;
    localparam int DATA_BITS = 8;
    localparam logic ODD_PARITY = 1'b1;
    function automatic logic parity_of(input logic [7:0] d);
        return ODD_PARITY ? ~^d : ^d;
    endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizer for one PS/2 pad plus a falling-edge detector.
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic pad,
    output logic level,
    output logic fall
);
    logic meta, prev;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) {meta, level, prev} <= 3'b111;
        else        {meta, level, prev} <= {pad, meta, level};
    end
    assign fall = prev & ~level;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter; inhibits the bus, then shifts a frame out on device clocks.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES   = 5000,
    parameter int TIMEOUT_CYCLES   = 750000,
    parameter int WAIT_IDLE_CYCLES = 50000
)(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe
);
    localparam int MAX_AB = (TIMEOUT_CYCLES > WAIT_IDLE_CYCLES) ? TIMEOUT_CYCLES : WAIT_IDLE_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > INHIBIT_CYCLES) ? MAX_AB : INHIBIT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] INH_START = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] WI_LAST   = CW'(WAIT_IDLE_CYCLES - 1);

    ps2_state_t    state;
    logic [7:0]    data;
    logic          parity;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] cnt, cnt_next;
    logic          clk_level, clk_fall, data_level, unused_data_fall;

    ps2_sync_edge u_clk  (.clock(clock), .reset(reset), .pad(ps2_clock_in), .level(clk_level),  .fall(clk_fall));
    ps2_sync_edge u_data (.clock(clock), .reset(reset), .pad(ps2_data_in),  .level(data_level), .fall(unused_data_fall));

    assign cnt_next = (cnt == '1) ? cnt : cnt + CW'(1);
    assign tx_ready = (state == IDLE);

    // One counter serves the inhibit period, the per-edge timeout and the idle wait.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            data         <= '0;
            parity       <= 1'b0;
            bit_cnt      <= '0;
            cnt          <= '0;
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            tx_done      <= 1'b0;
            tx_error     <= 1'b0;
            err_code     <= ERR_NONE;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            cnt      <= cnt_next;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        data         <= tx_data;
                        parity       <= parity_of(tx_data);
                        cnt          <= '0;
                        bit_cnt      <= '0;
                        ps2_clock_oe <= 1'b1;
                        state        <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_START) ps2_data_oe <= 1'b1;
                    if (cnt == INH_LAST) begin
                        ps2_clock_oe <= 1'b0;
                        cnt          <= '0;
                        state        <= START;
                    end
                end
                START, BITS, STOP, ACK: begin
                    if (clk_fall) begin
                        cnt     <= '0;
                        bit_cnt <= (bit_cnt == 4'hF) ? bit_cnt : bit_cnt + 4'd1;
                        if (state == STOP) begin
                            ps2_data_oe <= 1'b0;
                            state       <= ACK;
                        end else if (state == ACK) begin
                            tx_error <= data_level;
                            if (data_level) err_code <= ERR_NO_ACK;
                            state <= data_level ? IDLE : WAIT_IDLE;
                        end else begin
                            // bit_cnt counts edges already seen: 0..7 select data bits, 8 is parity
                            ps2_data_oe <= (bit_cnt < 4'(DATA_BITS)) ? ~data[bit_cnt[2:0]] : ~parity;
                            state       <= (bit_cnt == 4'(DATA_BITS)) ? STOP : BITS;
                        end
                    end else if (cnt == TO_LAST) begin
                        tx_error     <= 1'b1;
                        err_code     <= ERR_TIMEOUT;
                        ps2_clock_oe <= 1'b0;
                        ps2_data_oe  <= 1'b0;
                        state        <= IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_level && data_level) begin
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end else if (cnt == WI_LAST) begin
                        tx_error <= 1'b1;
                        err_code <= ERR_IDLE;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed frames against a PS/2 device model; a scoreboard checks every done/error pulse.
module tb_ps2_host_tx;
    localparam int INH = 50;
    localparam int TO  = 400;
    localparam int WI  = 300;
    localparam int H   = 10;

    typedef struct {
        bit         err;
        logic [1:0] code;
        bit         frame;
        logic [7:0] b;
        logic       p;
        int         lat;
    } exp_t;

    logic       clock, reset;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, tx_done, tx_error;
    logic [1:0] err_code;
    logic       clock_oe, data_oe, ps2_clock_in, ps2_data_in;
    logic       dev_clk, dev_dat;
    logic [7:0] rx_byte;
    logic       rx_par, rx_stop;
    int         n_vec = 0, n_bad = 0, cyc = 0, t_fall = 0;
    exp_t       q[$];

    assign ps2_clock_in = ~clock_oe & dev_clk;
    assign ps2_data_in  = ~data_oe & dev_dat;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .WAIT_IDLE_CYCLES(WI)) dut (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .err_code(err_code),
        .ps2_clock_in(ps2_clock_in), .ps2_data_in(ps2_data_in),
        .ps2_clock_oe(clock_oe), .ps2_data_oe(data_oe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic push(input bit err, input logic [1:0] code, input bit frame,
                        input logic [7:0] b, input logic p, input int lat);
        q.push_back('{err, code, frame, b, p, lat});
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset && (tx_done || tx_error)) begin
            chk("done_and_error_exclusive", {31'd0, tx_done & tx_error}, 0);
            chk("pulse_expected", {31'd0, q.size() != 0}, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pulse_kind_error", {31'd0, tx_error}, {31'd0, e.err});
                chk("err_code", {30'd0, err_code}, {30'd0, e.code});
                chk("oe_released", {30'd0, clock_oe, data_oe}, 0);
                chk("ready_at_pulse", {31'd0, tx_ready}, 1);
                if (e.frame) begin
                    chk("frame_byte", {24'd0, rx_byte}, {24'd0, e.b});
                    chk("frame_parity", {31'd0, rx_par}, {31'd0, e.p});
                    chk("frame_stop", {31'd0, rx_stop}, 1);
                end
                if (e.lat != 0) chk("timeout_latency", cyc - t_fall, e.lat);
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit drop);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clock);
        chk("accept_ready_low", {31'd0, tx_ready}, 0);
        if (drop) tx_valid = 1'b0;
    endtask

    // ack_mode: 0 no ack, 1 ack then release, 2 ack and keep data low
    task automatic dev_frame(input int n, input int ack_mode);
        int w = 0, hi = 0, dhi = 0;
        while (!clock_oe && w < 400) begin @(negedge clock); w++; end
        chk("inhibit_seen", {31'd0, clock_oe}, 1);
        if (!clock_oe) return;
        while (clock_oe && hi < 2000) begin
            hi++;
            dhi += int'(data_oe);
            @(negedge clock);
        end
        chk("inhibit_len", hi, INH);
        chk("start_bit_last_inhibit_cycle", dhi, 1);
        chk("start_bit_after_release", {31'd0, data_oe}, 1);
        repeat (15) @(negedge clock);
        for (int e = 1; e <= n; e++) begin
            if (e == 11 && ack_mode != 0) dev_dat = 1'b0;
            dev_clk = 1'b0;
            t_fall  = cyc;
            repeat (H) @(negedge clock);
            if (e <= 8) rx_byte[e-1] = ps2_data_in;
            else if (e == 9) rx_par = ps2_data_in;
            else if (e == 10) rx_stop = ps2_data_in;
            dev_clk = 1'b1;
            repeat (H) @(negedge clock);
            if (e == 11 && ack_mode == 1) dev_dat = 1'b1;
        end
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 3000) begin @(negedge clock); w++; end
        chk("responses_drained", q.size(), 0);
        q.delete();
    endtask

    initial begin
        int w, early;
        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_dat = 1'b1;
        rx_byte = 8'h00; rx_par = 1'b0; rx_stop = 1'b0;
        #2 reset = 1'b0;
        #2;
        chk("reset_ready", {31'd0, tx_ready}, 1);
        chk("reset_oe", {30'd0, clock_oe, data_oe}, 0);
        chk("reset_pulses", {30'd0, tx_done, tx_error}, 0);
        chk("reset_err_code", {30'd0, err_code}, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        push(0, 2'b00, 1, 8'hED, 1'b1, 0);
        send(8'hED, 1); dev_frame(11, 1); drain();

        push(1, 2'b10, 1, 8'h00, 1'b1, 0);
        send(8'h00, 1); dev_frame(11, 0); drain();

        push(1, 2'b01, 0, 8'hA5, 1'b0, TO + 3);
        send(8'hA5, 1); dev_frame(5, 0); drain();

        push(1, 2'b11, 1, 8'h3C, 1'b1, 0);
        send(8'h3C, 1); dev_frame(11, 2); drain();
        dev_dat = 1'b1;
        repeat (5) @(negedge clock);

        push(0, 2'b11, 1, 8'hA0, 1'b1, 0);
        send(8'hA0, 1); dev_frame(11, 1); drain();

        send(8'h55, 1); dev_frame(4, 0);
        chk("pre_reset_data_oe", {31'd0, data_oe}, 1);
        reset = 1'b0;
        #1;
        chk("midframe_reset_oe", {30'd0, clock_oe, data_oe}, 0);
        chk("midframe_reset_ready", {31'd0, tx_ready}, 1);
        chk("midframe_reset_pulses", {30'd0, tx_done, tx_error}, 0);
        chk("midframe_reset_err_code", {30'd0, err_code}, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        push(0, 2'b00, 1, 8'hF4, 1'b0, 0);
        send(8'hF4, 1); dev_frame(11, 1); drain();

        push(0, 2'b00, 1, 8'hFF, 1'b1, 0);
        push(0, 2'b00, 1, 8'h12, 1'b1, 0);
        send(8'hFF, 0);
        fork
            dev_frame(11, 1);
            begin repeat (100) @(negedge clock); tx_data = 8'h12; end
        join
        w = 0; early = 0;
        while (!tx_done && w < 2000) begin
            @(negedge clock);
            w++;
            early += int'(clock_oe);
        end
        chk("first_frame_done", {31'd0, tx_done}, 1);
        chk("no_second_frame_before_done", early, 0);
        fork
            dev_frame(11, 1);
            begin @(negedge clock); tx_valid = 1'b0; end
        join
        drain();

        repeat (5) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
